pio_edge_irq_gen: RTL and testbench

- Parametrised Avalon-MM parallel I/O slave; next generation of the single-bit input PIO.
- WIDTH-bit input port with 2-flop synchroniser, optional per-bit debounce, selectable edge type, per-bit edge capture with write-1-to-clear, per-bit IRQ mask.
- Adds a WIDTH-bit output port with atomic set/clear registers.
- Sits on the Nios system interconnect; irq goes to the CPU interrupt controller.

---
 rtl/pio_pkg.sv | 17 +
 rtl/pio_debounce.sv | 52 +++++
 rtl/pio_edge_irq_gen.sv | 106 ++++++++++
 tb/tb_pio_edge_irq_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map and edge-mode constants for the parallel I/O slave.
package pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_OUT_RB  = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5
  } pio_addr_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit debouncer: accepts a change on din_i only after it has
// differed from the current output for DEBOUNCE_CYCLES consecutive clocks.
// DEBOUNCE_CYCLES = 0 degenerates to a plain wire.
module pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic db_o
);

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ reset_n;
    assign db_o = din_i;
  end else begin : g_filter
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // Count consecutive disagreeing cycles; commit the new level on the last one.
    always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (din_i == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        db_d  = din_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        db_q  <= db_d;
      end
    end

    assign db_o = db_q;
  end

endmodule

// File: rtl/pio_edge_irq_gen.sv
// Avalon-MM parallel I/O slave: synchronised/debounced input port with
// per-bit edge capture and maskable level IRQ, plus an output port with
// atomic set/clear registers. Read latency is one clock.
module pio_edge_irq_gen
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_MODE       = EDGE_RISE,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic [31:0] RESET_OUT       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s2_q, db_w, prev_q, edge_w;
  logic [WIDTH-1:0] cap_q, cap_d, mask_q, mask_d, out_q, out_d, clr_w;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] wd;
  logic [31:0]      unused_wd;
  logic             wr_en;

  assign wr_en     = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = writedata;

  // Per-bit debounce of the synchronised input.
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din_i   (s2_q[i]),
      .db_o    (db_w[i])
    );
  end

  if (EDGE_MODE == EDGE_FALL) begin : g_fall
    assign edge_w = ~db_w & prev_q;
  end else if (EDGE_MODE == EDGE_ANY) begin : g_any
    assign edge_w = db_w ^ prev_q;
  end else begin : g_rise
    assign edge_w = db_w & ~prev_q;
  end

  // Register write decode, edge capture update and read mux.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr_w  = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    out_d  = wd;
        ADDR_IRQMASK: mask_d = wd;
        ADDR_EDGECAP: clr_w  = wd;
        ADDR_OUTSET:  out_d  = out_q | wd;
        ADDR_OUTCLR:  out_d  = out_q & ~wd;
        default:      ;
      endcase
    end
    // Set is OR-ed after the clear so a coincident edge is never lost.
    cap_d = (cap_q & ~clr_w) | edge_w;

    rd_d = '0;
    case (address)
      ADDR_DATA:    rd_d[WIDTH-1:0] = db_w;
      ADDR_OUT_RB:  rd_d[WIDTH-1:0] = out_q;
      ADDR_IRQMASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd_d[WIDTH-1:0] = cap_q;
      default:      ;
    endcase
  end

  // Synchroniser, history and register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      cap_q  <= '0;
      mask_q <= '0;
      out_q  <= RESET_OUT[WIDTH-1:0];
      rd_q   <= '0;
    end else begin
      s1_q   <= in_port;
      s2_q   <= s1_q;
      prev_q <= db_w;
      cap_q  <= cap_d;
      mask_q <= mask_d;
      out_q  <= out_d;
      rd_q   <= rd_d;
    end
  end

  assign out_port = out_q;
  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_edge_irq_gen.sv
// Directed bench for pio_edge_irq_gen: three instances share the bus
// (rising/no-debounce with RESET_OUT=A5, rising with 4-cycle debounce,
// any-edge) and each has its own input port.
module tb_pio_edge_irq_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [7:0]  in_a, in_b, in_c, out_a, out_b, out_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  pio_edge_irq_gen #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(0), .RESET_OUT(32'hA5)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a), .out_port(out_a),
    .readdata(rd_a), .irq(irq_a));

  pio_edge_irq_gen #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4), .RESET_OUT(32'h0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b), .out_port(out_b),
    .readdata(rd_b), .irq(irq_b));

  pio_edge_irq_gen #(.WIDTH(8), .EDGE_MODE(2), .DEBOUNCE_CYCLES(0), .RESET_OUT(32'h0)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_c), .out_port(out_c),
    .readdata(rd_c), .irq(irq_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; returns just after a falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in_a = '0; in_b = '0; in_c = '0;
    tick(2);
    check("rst_out_a", {24'h0, out_a}, 32'hA5);
    check("rst_out_b", {24'h0, out_b}, 32'h00);
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_irq_a", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    rd(3'd2); check("rd_mask_rst", rd_a, 32'h0);
    rd(3'd3); check("rd_cap_rst", rd_a, 32'h0);

    // Rising edge on bit 2, three-clock capture latency
    wr(3'd2, 32'h04);
    rd(3'd2); check("rd_mask", rd_a, 32'h04);
    in_a[2] = 1'b1;
    tick(2); check("irq_before_lat", {31'h0, irq_a}, 32'h0);
    tick(1); check("irq_lat3", {31'h0, irq_a}, 32'h1);
    rd(3'd3); check("cap_bit2", rd_a, 32'h04);
    wr(3'd3, 32'h04); check("irq_clr", {31'h0, irq_a}, 32'h0);

    // Falling edge ignored in rising mode
    in_a[2] = 1'b0;
    tick(4);
    rd(3'd3); check("fall_ignored", rd_a, 32'h0);

    // Edge and write-1-clear on the same clock: set wins
    in_a[2] = 1'b1;
    tick(2);
    wr(3'd3, 32'h04);
    check("set_wins_irq", {31'h0, irq_a}, 32'h1);
    rd(3'd3); check("set_wins_cap", rd_a, 32'h04);
    wr(3'd3, 32'h00); check("w0_keeps", {31'h0, irq_a}, 32'h1);
    wr(3'd3, 32'h04); check("w1_clears", {31'h0, irq_a}, 32'h0);

    // Debounce N=4: 3-cycle pulse rejected, sustained level accepted
    in_b[0] = 1'b1;
    tick(3);
    in_b[0] = 1'b0;
    tick(6);
    rd(3'd0); check("db_short_data", rd_b, 32'h0);
    rd(3'd3); check("db_short_cap", rd_b, 32'h0);
    in_b[0] = 1'b1;
    tick(4);
    rd(3'd0); check("db_not_yet", rd_b, 32'h0);
    tick(1);
    rd(3'd0); check("db_long_data", rd_b, 32'h01);
    rd(3'd3); check("db_long_cap", rd_b, 32'h01);

    // Any-edge mode captures both transitions
    in_c[1] = 1'b1;
    tick(3);
    rd(3'd3); check("any_rise", rd_c, 32'h02);
    wr(3'd3, 32'h02);
    rd(3'd3); check("any_cleared", rd_c, 32'h0);
    in_c[1] = 1'b0;
    tick(3);
    rd(3'd3); check("any_fall", rd_c, 32'h02);

    // Output port write / set / clear and readback
    wr(3'd0, 32'h0F); check("out_write", {24'h0, out_a}, 32'h0F);
    wr(3'd4, 32'h30); check("out_set", {24'h0, out_a}, 32'h3F);
    wr(3'd5, 32'h01); check("out_clr", {24'h0, out_a}, 32'h3E);
    check("out_b", {24'h0, out_b}, 32'h3E);
    rd(3'd1); check("out_readback", rd_a, 32'h3E);
    rd(3'd6); check("rd_unmapped", rd_a, 32'h0);

    // Reset mid-operation discards state; held-high inputs then re-edge
    reset_n = 1'b0;
    tick(1);
    check("rst2_out_a", {24'h0, out_a}, 32'hA5);
    check("rst2_irq_a", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    rd(3'd3);
    check("rst2_cap_b", rd_b, 32'h0);
    check("rst2_cap_c", rd_c, 32'h0);
    tick(8);
    rd(3'd3);
    check("post_rst_rise_b", rd_b, 32'h01);
    check("post_rst_rise_a", rd_a, 32'h04);
    check("no_spurious_c", rd_c, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
